// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC and program memory, and feeds execute
// through a 2-entry instruction buffer over a valid/ready handshake.
//
// Ports:
//   clk, reset                        clock and async active-high reset
//   load_en/load_addr/load_data       program memory preload (word write)
//   instr_valid/instr/instr_pc        buffer head presented to execute
//   instr_ready                       execute accepts the head this cycle
//   redirect_valid/redirect_pc        fetch restart request from execute
//   misalign_err                      sticky flag for an unaligned redirect
module instr_fetch_unit #(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam logic [2:0]  DEPTH = 3'(BUF_DEPTH);

    logic [31:0] mem_q [MEM_WORDS];

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] rdata_q;
    logic [31:0] rpc_q;

    logic [1:0]  count_q, count_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        err_q, err_d;

    logic        pop;
    logic [2:0]  occ;
    logic [1:0]  cnt_pop;
    logic        issue;
    logic [31:0] rd_pc;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{load_addr[31:AW+2], load_addr[1:0]};

    assign instr_valid  = (count_q != 2'd0);
    assign instr        = head_instr_q;
    assign instr_pc     = head_pc_q;
    assign misalign_err = err_q;

    // Loads are not gated by reset so a program can be preloaded while
    // the core is held in reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr[AW+1:2]] <= load_data;
        end
    end

    always_comb begin
        pop     = instr_valid & instr_ready;
        // Occupancy after this edge's pop, counting the read in flight;
        // issuing only below depth guarantees the buffer cannot overflow.
        occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        cnt_pop = count_q - {1'b0, pop};
        rd_pc   = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc_q;
        issue   = redirect_valid | (occ < DEPTH);

        fetch_pc_d   = issue ? rd_pc + 32'd4 : fetch_pc_q;
        inflight_d   = issue;
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        err_d        = err_q;

        if (redirect_valid) begin
            // Flush; the old in-flight read is dropped, and rd_pc has
            // already been steered to the target.
            count_d = 2'd0;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end else begin
            if (pop) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
            end
            if (inflight_q) begin
                if (cnt_pop == 2'd0) begin
                    head_instr_d = rdata_q;
                    head_pc_d    = rpc_q;
                end else begin
                    tail_instr_d = rdata_q;
                    tail_pc_d    = rpc_q;
                end
            end
            count_d = cnt_pop + {1'b0, inflight_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            inflight_q   <= 1'b0;
            rdata_q      <= 32'h0;
            rpc_q        <= 32'h0;
            count_q      <= 2'd0;
            head_instr_q <= 32'h0;
            head_pc_q    <= 32'h0;
            tail_instr_q <= 32'h0;
            tail_pc_q    <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
            err_q        <= err_d;
            if (issue) begin
                rdata_q <= mem_q[rd_pc[AW+1:2]];
                rpc_q   <= rd_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int          MW  = 64;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .MEM_WORDS(MW),
        .RESET_PC (RPC),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .misalign_err  (misalign_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        bq[$];
    ent_t        fq[$];
    logic [31:0] mem_m [MW];
    logic [31:0] fpc;
    logic        err;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % MW);
    endfunction

    function automatic logic [31:0] addi(input int i);
        return {12'(i), 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        fq.delete();
        fpc = RPC;
        err = 1'b0;
    endtask

    // One clock edge of the fetch unit described in terms of what is
    // buffered, what is in flight and where fetching continues.
    task automatic model_edge();
        ent_t        e;
        int          occ;
        bit          pop;
        logic [31:0] tgt;
        if (reset) begin
            model_reset();
        end else begin
            pop = (bq.size() > 0) && instr_ready;
            occ = bq.size() + fq.size() - (pop ? 1 : 0);
            if (redirect_valid) begin
                bq.delete();
                fq.delete();
                tgt    = redirect_pc & ~32'h3;
                e.pc   = tgt;
                e.data = mem_m[widx(tgt)];
                fq.push_back(e);
                fpc = tgt + 32'd4;
                if (redirect_pc[1:0] != 2'b00) err = 1'b1;
            end else begin
                if (pop) void'(bq.pop_front());
                if (fq.size() > 0) bq.push_back(fq.pop_front());
                if (occ < 2) begin
                    e.pc   = fpc;
                    e.data = mem_m[widx(fpc)];
                    fq.push_back(e);
                    fpc = fpc + 32'd4;
                end
            end
        end
        if (load_en) mem_m[widx(load_addr)] = load_data;
    endtask

    task automatic cmp_all();
        chk("valid", {31'b0, instr_valid}, {31'b0, bq.size() > 0});
        if (bq.size() > 0) begin
            chk("instr", instr, bq[0].data);
            chk("instr_pc", instr_pc, bq[0].pc);
        end
        chk("misalign", {31'b0, misalign_err}, {31'b0, err});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_valid", {31'b0, instr_valid}, 32'd0);
        step();
        reset = 1'b0;
    endtask

    task automatic redir(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);

        // Preload during reset; low address bits must be ignored.
        for (int i = 0; i < MW; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i * 4) | 32'($urandom_range(0, 3));
            load_data = (i < 5) ? addi(i + 1) : $urandom;
            step();
        end
        load_en = 1'b0;

        // 1: streaming after reset release
        reset = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("t1_edge1_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk("t1_first_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_pc0", instr_pc, 32'd0);
        chk("t1_instr0", instr, addi(1));
        for (int i = 1; i < 5; i++) begin
            step();
            chk("t1_pc", instr_pc, 32'(i * 4));
            chk("t1_instr", instr, addi(i + 1));
        end

        // 2: stall with a held head
        do_reset();
        instr_ready = 1'b1;
        step();
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_held_pc", instr_pc, 32'd0);
            chk("t2_held_instr", instr, addi(1));
        end
        instr_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            chk("t2_resume_pc", instr_pc, 32'(i * 4));
        end

        // 3: redirect while pc=8 is accepted
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t3_pre_pc", instr_pc, 32'd8);
        redir(32'h40);
        chk("t3_bubble", {31'b0, instr_valid}, 32'd0);
        step();
        chk("t3_tgt_valid", {31'b0, instr_valid}, 32'd1);
        chk("t3_tgt_pc", instr_pc, 32'h40);
        step();
        chk("t3_next_pc", instr_pc, 32'h44);

        // 4: misaligned redirect is sticky
        redir(32'h22);
        chk("t4_err_set", {31'b0, misalign_err}, 32'd1);
        step();
        chk("t4_pc", instr_pc, 32'h20);
        redir(32'h80);
        step();
        chk("t4_err_sticky", {31'b0, misalign_err}, 32'd1);
        chk("t4_pc2", instr_pc, 32'h80);

        // 5: wrap past the last word
        redir(32'((MW - 1) * 4));
        step();
        chk("t5_last_pc", instr_pc, 32'((MW - 1) * 4));
        step();
        chk("t5_wrap_pc", instr_pc, 32'(MW * 4));
        chk("t5_wrap_instr", instr, mem_m[0]);

        // 6: reset with a full buffer
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        #1;
        model_reset();
        chk("t6_async_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_async_err", {31'b0, misalign_err}, 32'd0);
        step();
        reset = 1'b0;
        instr_ready = 1'b1;
        step();
        step();
        chk("t6_first_valid", {31'b0, instr_valid}, 32'd1);
        chk("t6_first_pc", instr_pc, RPC);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom_range(0, 511);
            load_en        = ($urandom_range(0, 7) == 0);
            load_addr      = $urandom_range(0, 1) ? fpc : $urandom;
            load_data      = $urandom;
            reset          = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        load_en = 1'b0;
        redirect_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
